// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared fetch-queue defines, data width, default depth and FSM state type.
`ifndef IFQ_DEFINES
`define IFQ_DEFINES
`define FULLW 32
`define IFQ_DEPTH 4
`define IFQ_IDLE 2'd0
`define IFQ_WAIT 2'd1
`define IFQ_DROP 2'd2
`endif

package ifetch_queue_pkg;
   localparam int FULLW = `FULLW;
   localparam int DEPTH_DEF = `IFQ_DEPTH;
   typedef enum logic [1:0] {
      IDLE = `IFQ_IDLE,
      WAIT = `IFQ_WAIT,
      DROP = `IFQ_DROP
   } state_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: power-of-two FIFO of {addr, instr} entries with flush and zeroed head when empty.
module ifq_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W = 2 * FULLW
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             dout
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign do_pop = reset_n && pop && !flush && count != '0;
   assign do_push = reset_n && push && !flush && (count != CW'(DEPTH) || do_pop);
   assign dout = count != '0 ? mem[rd_ptr] : '0;
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: single-outstanding instruction fetcher feeding a FIFO toward decode.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [FULLW-1:0] pc_addr,
   output logic             pc_en,
   input  logic             flush,
   output logic             imem_req,
   output logic [FULLW-1:0] imem_addr,
   input  logic             imem_rvalid,
   input  logic [FULLW-1:0] imem_rdata,
   output logic             out_valid,
   output logic [FULLW-1:0] out_instr,
   output logic [FULLW-1:0] out_addr,
   input  logic             out_ready
);
   localparam int CW = $clog2(DEPTH) + 1;
   state_t state, state_nx;
   logic [FULLW-1:0] tag;
   logic [CW-1:0] count;
   logic [2*FULLW-1:0] head;
   logic issue, push, pop;
   // Issue only from IDLE, so a full FIFO can never receive an extra response.
   always_comb begin
      issue = reset_n && state == IDLE && !flush && count < CW'(DEPTH);
      push = state == WAIT && imem_rvalid && !flush;
      out_valid = reset_n && count != '0;
      pop = out_valid && out_ready && !flush;
      state_nx = state == IDLE ? (issue ? WAIT : IDLE)
               : state == WAIT ? (imem_rvalid ? IDLE : flush ? DROP : WAIT)
               : (imem_rvalid ? IDLE : DROP);
   end
   assign pc_en = issue;
   assign imem_req = issue;
   assign imem_addr = pc_addr;
   assign out_addr = head[2*FULLW-1:FULLW];
   assign out_instr = head[FULLW-1:0];
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         tag   <= '0;
      end else begin
         state <= state_nx;
         if (issue) tag <= pc_addr;
      end
   end
   ifq_fifo #(.DEPTH(DEPTH), .W(2 * FULLW)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .din     ({tag, imem_rdata}),
      .count   (count),
      .dout    (head)
   );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed vector table plus responder-driven sequences for ifetch_queue.
module tb_ifetch_queue;
   logic        clk = 0, reset_n = 0, flush = 0, imem_rvalid = 0, out_ready = 0;
   logic        pc_en, imem_req, out_valid;
   logic [31:0] pc_addr = 0, imem_rdata = 0, imem_addr, out_instr, out_addr;
   int tests = 0, fails = 0;

   typedef struct {
      logic rst_n; logic [31:0] pc; logic fl, rv; logic [31:0] rd; logic rdy;
      logic pe, req, ov; logic [31:0] oi, oa;
   } vec_t;
   vec_t tv[$];

   logic pend = 0;
   logic [31:0] paddr = 0, pc = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   ifetch_queue dut (
      .clk(clk), .reset_n(reset_n), .pc_addr(pc_addr), .pc_en(pc_en), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .out_valid(out_valid), .out_instr(out_instr),
      .out_addr(out_addr), .out_ready(out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst_n, input logic [31:0] pcv, input logic fl, input logic rv,
                      input logic [31:0] rd, input logic rdy, input logic pe, input logic req,
                      input logic ov, input logic [31:0] oi, input logic [31:0] oa);
      vec_t v;
      v.rst_n = rst_n; v.pc = pcv; v.fl = fl; v.rv = rv; v.rd = rd; v.rdy = rdy;
      v.pe = pe; v.req = req; v.ov = ov; v.oi = oi; v.oa = oa;
      tv.push_back(v);
   endtask

   // One cycle against a memory that answers every request one cycle later.
   task automatic cyc(input logic rdy);
      @(negedge clk);
      reset_n = 1; flush = 0;
      imem_rvalid = pend; imem_rdata = paddr ^ 32'h5A5A0000;
      pc_addr = pc; out_ready = rdy;
      #1;
      if (imem_rvalid) pend = 0;
      if (pc_en) begin
         pend = 1; paddr = pc; pc += 4; pulses++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 0; flush = 0; imem_rvalid = 0; out_ready = 0;
      pend = 0; pc = 0; pulses = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_addr;
      int bad;
      logic prev, got;
      add(0, 'h0,   0, 0, 0,            1, 0, 0, 0, 0,            0);
      add(1, 'h0,   0, 0, 0,            1, 1, 1, 0, 0,            0);
      add(1, 'h4,   0, 1, 'h10000000,   1, 0, 0, 0, 0,            0);
      add(1, 'h4,   0, 0, 0,            1, 1, 1, 1, 'h10000000,   'h0);
      add(1, 'h8,   0, 1, 'h10000004,   1, 0, 0, 0, 0,            0);
      add(1, 'h8,   0, 0, 0,            1, 1, 1, 1, 'h10000004,   'h4);
      add(1, 'hC,   0, 1, 'h10000008,   1, 0, 0, 0, 0,            0);
      add(1, 'hC,   0, 0, 0,            0, 1, 1, 1, 'h10000008,   'h8);
      add(1, 'h10,  0, 1, 'h1000000C,   0, 0, 0, 1, 'h10000008,   'h8);
      add(1, 'h10,  0, 0, 0,            0, 1, 1, 1, 'h10000008,   'h8);
      add(1, 'h14,  0, 1, 'h10000010,   0, 0, 0, 1, 'h10000008,   'h8);
      add(1, 'h14,  0, 0, 0,            0, 1, 1, 1, 'h10000008,   'h8);
      add(1, 'h18,  0, 1, 'h10000014,   0, 0, 0, 1, 'h10000008,   'h8);
      add(1, 'h18,  0, 0, 0,            0, 0, 0, 1, 'h10000008,   'h8);
      add(1, 'h18,  0, 0, 0,            0, 0, 0, 1, 'h10000008,   'h8);
      add(1, 'h18,  0, 0, 0,            1, 0, 0, 1, 'h10000008,   'h8);
      add(1, 'h18,  0, 0, 0,            0, 1, 1, 1, 'h1000000C,   'hC);
      add(1, 'h1C,  0, 1, 'h10000018,   1, 0, 0, 1, 'h1000000C,   'hC);
      add(1, 'h1C,  0, 0, 0,            0, 1, 1, 1, 'h10000010,   'h10);
      add(1, 'h20,  0, 1, 'h1000001C,   1, 0, 0, 1, 'h10000010,   'h10);
      add(1, 'h20,  0, 0, 0,            1, 1, 1, 1, 'h10000014,   'h14);
      add(1, 'h24,  0, 0, 0,            1, 0, 0, 1, 'h10000018,   'h18);
      add(1, 'h24,  1, 0, 0,            1, 0, 0, 1, 'h1000001C,   'h1C);
      add(1, 'h100, 0, 0, 0,            1, 0, 0, 0, 0,            0);
      add(1, 'h100, 0, 0, 0,            1, 0, 0, 0, 0,            0);
      add(1, 'h100, 0, 1, 'hDEADBEEF,   1, 0, 0, 0, 0,            0);
      add(1, 'h100, 0, 0, 0,            1, 1, 1, 0, 0,            0);
      add(1, 'h104, 0, 1, 'h20000100,   0, 0, 0, 0, 0,            0);
      add(1, 'h104, 0, 0, 0,            0, 1, 1, 1, 'h20000100,   'h100);
      add(1, 'h108, 0, 1, 'h20000104,   0, 0, 0, 1, 'h20000100,   'h100);
      add(1, 'h108, 0, 0, 0,            0, 1, 1, 1, 'h20000100,   'h100);
      add(1, 'h200, 1, 1, 'hBAD,        0, 0, 0, 1, 'h20000100,   'h100);
      add(1, 'h200, 0, 0, 0,            0, 1, 1, 0, 0,            0);
      add(0, 'h204, 0, 0, 0,            0, 0, 0, 0, 0,            0);
      add(1, 'h300, 0, 1, 'hBAD2,       1, 1, 1, 0, 0,            0);
      add(1, 'h304, 0, 0, 0,            1, 0, 0, 0, 0,            0);
      add(1, 'h304, 0, 1, 'h30000300,   1, 0, 0, 0, 0,            0);
      add(1, 'h304, 0, 0, 0,            1, 1, 1, 1, 'h30000300,   'h300);
      foreach (tv[i]) begin
         @(negedge clk);
         reset_n = tv[i].rst_n; pc_addr = tv[i].pc; flush = tv[i].fl;
         imem_rvalid = tv[i].rv; imem_rdata = tv[i].rd; out_ready = tv[i].rdy;
         #1;
         check($sformatf("v%0d pc_en", i), {31'd0, pc_en}, {31'd0, tv[i].pe});
         check($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, tv[i].req});
         check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ov});
         if (tv[i].req) check($sformatf("v%0d imem_addr", i), imem_addr, tv[i].pc);
         if (tv[i].ov || tv[i].rst_n) begin
            check($sformatf("v%0d out_instr", i), out_instr, tv[i].oi);
            check($sformatf("v%0d out_addr", i), out_addr, tv[i].oa);
         end
      end
      // Streaming with a ready consumer: one fetch every two cycles, addresses in order.
      do_reset();
      exp_addr = 0; bad = 0; prev = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (pc_en && prev) bad++;
         prev = pc_en;
         if (out_valid) begin
            check("stream addr", out_addr, exp_addr);
            check("stream instr", out_instr, exp_addr ^ 32'h5A5A0000);
            exp_addr += 4;
         end
      end
      check("stream pulses", pulses, 12 / 2);
      check("stream back-to-back pc_en", bad, 0);
      check("stream pops", exp_addr, 32'd20);
      // Stalled consumer: queue fills, then one pop frees exactly one more fetch.
      do_reset();
      for (int i = 0; i < 20; i++) cyc(0);
      check("full pulses", pulses, 4);
      check("full out_valid", {31'd0, out_valid}, 32'd1);
      check("full head addr", out_addr, 32'd0);
      cyc(1);
      check("full pop-cycle pc_en", {31'd0, pc_en}, 32'd0);
      got = 0;
      for (int k = 0; k < 5 && !got; k++) begin
         cyc(0);
         if (pc_en) got = 1;
      end
      check("refill issue seen", {31'd0, got}, 32'd1);
      check("refill pulses", pulses, 5);
      check("refill head addr", out_addr, 32'd4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
